// File: rtl/ysyx_22050598_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and stage indices.
package ysyx_22050598_hazard_ctrl_pkg;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_PEND = 1'b1
    } redir_state_e;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned STG_IF = 0;
    localparam int unsigned STG_ID = 1;
    localparam int unsigned STG_EX = 2;

endpackage

// File: rtl/ysyx_22050598_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
module ysyx_22050598_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ysyx_22050598_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush masks, redirect handshake,
// mul/div issue sequencing and saturating stall/flush statistics.
module ysyx_22050598_hazard_ctrl
    import ysyx_22050598_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned EX_IDX = STG_EX,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_br_valid,
    input  logic [XLEN-1:0]   ex_br_target,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_target,
    input  logic              ifu_busy,
    input  logic              redirect_ready,
    input  logic              ex_is_muldiv,
    input  logic              muldiv_out_valid,
    input  logic              lsu_busy,
    input  logic              load_use,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              muldiv_start,
    output logic [CNT_W-1:0]  perf_stall_cycles,
    output logic [CNT_W-1:0]  perf_flush_count
);

    redir_state_e      r_state_q, r_state_d;
    md_state_e         m_state_q, m_state_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;
    logic              mispred;
    logic              kill;
    logic              flush_evt;
    logic              start;
    logic              mul_stall;
    logic              full_stall;
    logic [NSTAGE-1:0] stall_raw, flush_raw;

    // A mispredict seen while a redirect is pending cannot be legal, so it is not acted on.
    assign mispred = ex_br_valid && (ex_br_target != id_pc);
    assign kill    = trap_valid || (mispred && (r_state_q == R_IDLE));

    always_comb begin
        r_state_d = r_state_q;
        rpc_d     = rpc_q;
        flush_evt = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (trap_valid) begin
                    rpc_d     = trap_target;
                    r_state_d = R_PEND;
                    flush_evt = 1'b1;
                end else if (mispred) begin
                    rpc_d     = ex_br_target;
                    r_state_d = R_PEND;
                    flush_evt = 1'b1;
                end
            end
            R_PEND: begin
                if (trap_valid) begin
                    rpc_d     = trap_target;
                    flush_evt = 1'b1;
                end else if (redirect_ready) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        m_state_d = m_state_q;
        start     = 1'b0;
        mul_stall = 1'b0;
        unique case (m_state_q)
            M_IDLE: begin
                if (ex_is_muldiv && !kill) begin
                    start     = 1'b1;
                    m_state_d = M_BUSY;
                end
            end
            M_BUSY: begin
                if (trap_valid || muldiv_out_valid) begin
                    m_state_d = M_IDLE;
                end else begin
                    mul_stall = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        full_stall = mul_stall || lsu_busy || (ifu_busy && (r_state_q == R_IDLE));
        stall_raw  = '0;
        flush_raw  = '0;
        if (full_stall) begin
            stall_raw = '1;
        end else if (load_use) begin
            for (int unsigned i = 0; i < EX_IDX; i++) begin
                stall_raw[i] = 1'b1;
            end
            flush_raw[EX_IDX] = 1'b1;
        end
        for (int unsigned i = 1; i < NSTAGE; i++) begin
            if (trap_valid || (mispred && (r_state_q == R_IDLE) && (i <= EX_IDX))) begin
                flush_raw[i] = 1'b1;
            end
        end
        // Hold the PC and discard whatever the IFU returns until the redirect is taken.
        if (r_state_q == R_PEND) begin
            stall_raw[0] = 1'b1;
            flush_raw[1] = 1'b1;
        end
        flush_raw[0] = 1'b0;
    end

    // Flush beats stall on every stage except the PC, which has no flush.
    assign stall          = rst_n ? (stall_raw & ~{flush_raw[NSTAGE-1:1], 1'b0}) : '0;
    assign flush          = rst_n ? flush_raw : '0;
    assign muldiv_start   = rst_n && start;
    assign redirect_valid = (r_state_q == R_PEND);
    assign redirect_pc    = rpc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            m_state_q <= M_IDLE;
            rpc_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            m_state_q <= m_state_d;
            rpc_q     <= rpc_d;
        end
    end

    ysyx_22050598_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (|stall),
        .count(perf_stall_cycles)
    );

    ysyx_22050598_sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush_evt),
        .count(perf_flush_count)
    );

endmodule

// File: tb/tb_ysyx_22050598_hazard_ctrl.sv
// Directed bench for the hazard controller; expectations are queued per cycle and
// checked by an independent monitor on the falling edge.
module tb_ysyx_22050598_hazard_ctrl;

    localparam int unsigned NSTAGE = 5;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              ex_br_valid;
    logic [XLEN-1:0]   ex_br_target;
    logic [XLEN-1:0]   id_pc;
    logic              trap_valid;
    logic [XLEN-1:0]   trap_target;
    logic              ifu_busy;
    logic              redirect_ready;
    logic              ex_is_muldiv;
    logic              muldiv_out_valid;
    logic              lsu_busy;
    logic              load_use;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              muldiv_start;
    logic [CNT_W-1:0]  perf_stall_cycles;
    logic [CNT_W-1:0]  perf_flush_count;

    ysyx_22050598_hazard_ctrl #(
        .NSTAGE(NSTAGE),
        .EX_IDX(2),
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_br_valid      (ex_br_valid),
        .ex_br_target     (ex_br_target),
        .id_pc            (id_pc),
        .trap_valid       (trap_valid),
        .trap_target      (trap_target),
        .ifu_busy         (ifu_busy),
        .redirect_ready   (redirect_ready),
        .ex_is_muldiv     (ex_is_muldiv),
        .muldiv_out_valid (muldiv_out_valid),
        .lsu_busy         (lsu_busy),
        .load_use         (load_use),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .muldiv_start     (muldiv_start),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count)
    );

    typedef struct {
        string       name;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        rv;
        logic [63:0] rpc;
        logic        start;
        logic [3:0]  psc;
        logic [3:0]  pfc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] rd_q[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    int unsigned psc_m  = 0;
    int unsigned pfc_m  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string n, input string f, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", n, f, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk(me.name, "stall", 64'(stall), 64'(me.stall));
            chk(me.name, "flush", 64'(flush), 64'(me.flush));
            chk(me.name, "redirect_valid", 64'(redirect_valid), 64'(me.rv));
            chk(me.name, "redirect_pc", redirect_pc, me.rpc);
            chk(me.name, "muldiv_start", 64'(muldiv_start), 64'(me.start));
            chk(me.name, "perf_stall", 64'(perf_stall_cycles), 64'(me.psc));
            chk(me.name, "perf_flush", 64'(perf_flush_count), 64'(me.pfc));
        end
        if (rst_n && redirect_valid && redirect_ready) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake: got pc %0h accepted, expected no redirect", redirect_pc);
            end else begin
                chk("handshake", "pc", redirect_pc, rd_q.pop_front());
            end
        end
    end

    // Queue one cycle's expectation, advance the counter model, then move to the next cycle.
    task automatic step(input string name, input logic [4:0] s, input logic [4:0] f,
                        input logic rv, input logic [63:0] rpc, input logic st,
                        input logic evt);
        exp_t e;
        if (!rst_n) begin
            psc_m = 0;
            pfc_m = 0;
        end
        e.name  = name;
        e.stall = s;
        e.flush = f;
        e.rv    = rv;
        e.rpc   = rpc;
        e.start = st;
        e.psc   = 4'(psc_m);
        e.pfc   = 4'(pfc_m);
        exp_q.push_back(e);
        if (rst_n) begin
            if ((s != 5'b0) && (psc_m < 15)) psc_m++;
            if (evt && (pfc_m < 15)) pfc_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        ex_br_valid      = 1'b0;
        ex_br_target     = '0;
        id_pc            = '0;
        trap_valid       = 1'b0;
        trap_target      = '0;
        ifu_busy         = 1'b0;
        redirect_ready   = 1'b0;
        ex_is_muldiv     = 1'b0;
        muldiv_out_valid = 1'b0;
        lsu_busy         = 1'b0;
        load_use         = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear();
        ifu_busy = 1'b1;
        lsu_busy = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);
        rst_n = 1'b1;
        clear();
        step("idle", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);

        // Mispredict and a delayed redirect acceptance
        ex_br_valid  = 1'b1;
        ex_br_target = 64'h8000_0010;
        id_pc        = 64'h8000_0008;
        step("mispred", 5'b00000, 5'b00110, 0, 64'h0, 0, 1);
        clear();
        for (int k = 0; k < 3; k++) begin
            step("rpend_wait", 5'b00001, 5'b00010, 1, 64'h8000_0010, 0, 0);
        end
        redirect_ready = 1'b1;
        rd_q.push_back(64'h8000_0010);
        step("rpend_accept", 5'b00001, 5'b00010, 1, 64'h8000_0010, 0, 0);
        clear();
        step("redirect_done", 5'b00000, 5'b00000, 0, 64'h8000_0010, 0, 0);

        // Correct prediction produces nothing
        ex_br_valid  = 1'b1;
        ex_br_target = 64'h8000_0020;
        id_pc        = 64'h8000_0020;
        step("pred_ok", 5'b00000, 5'b00000, 0, 64'h8000_0010, 0, 0);
        clear();
        step("pred_ok_next", 5'b00000, 5'b00000, 0, 64'h8000_0010, 0, 0);

        // Mul/div with a result seven busy cycles after start, from fresh counters
        rst_n = 1'b0;
        step("reset2", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);
        rst_n = 1'b1;
        ex_is_muldiv = 1'b1;
        step("md_start", 5'b00000, 5'b00000, 0, 64'h0, 1, 0);
        for (int k = 0; k < 7; k++) begin
            step("md_busy", 5'b11111, 5'b00000, 0, 64'h0, 0, 0);
        end
        muldiv_out_valid = 1'b1;
        step("md_done", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);
        clear();
        step("md_after", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);

        // Trap aborts a multiply in flight
        ex_is_muldiv = 1'b1;
        step("md2_start", 5'b00000, 5'b00000, 0, 64'h0, 1, 0);
        step("md2_busy", 5'b11111, 5'b00000, 0, 64'h0, 0, 0);
        trap_valid  = 1'b1;
        trap_target = 64'h8000_0100;
        step("md2_trap", 5'b00000, 5'b11110, 0, 64'h0, 0, 1);
        clear();
        muldiv_out_valid = 1'b1;
        step("late_valid", 5'b00001, 5'b00010, 1, 64'h8000_0100, 0, 0);
        muldiv_out_valid = 1'b0;
        redirect_ready   = 1'b1;
        rd_q.push_back(64'h8000_0100);
        step("trap_accept", 5'b00001, 5'b00010, 1, 64'h8000_0100, 0, 0);
        clear();
        step("trap_done", 5'b00000, 5'b00000, 0, 64'h8000_0100, 0, 0);

        // Trap overwrites a pending mispredict redirect
        ex_br_valid  = 1'b1;
        ex_br_target = 64'h8000_0040;
        id_pc        = 64'h8000_0044;
        step("mispred2", 5'b00000, 5'b00110, 0, 64'h8000_0100, 0, 1);
        clear();
        trap_valid  = 1'b1;
        trap_target = 64'h8000_0200;
        step("trap_overwrite", 5'b00001, 5'b11110, 1, 64'h8000_0040, 0, 1);
        clear();
        step("ovw_wait", 5'b00001, 5'b00010, 1, 64'h8000_0200, 0, 0);
        redirect_ready = 1'b1;
        rd_q.push_back(64'h8000_0200);
        step("ovw_accept", 5'b00001, 5'b00010, 1, 64'h8000_0200, 0, 0);
        clear();
        step("ovw_done", 5'b00000, 5'b00000, 0, 64'h8000_0200, 0, 0);

        // Load-use bubble, then suppressed by a backend stall
        load_use = 1'b1;
        step("load_use", 5'b00011, 5'b00100, 0, 64'h8000_0200, 0, 0);
        lsu_busy = 1'b1;
        step("load_use_lsu", 5'b11111, 5'b00000, 0, 64'h8000_0200, 0, 0);
        clear();
        step("lu_done", 5'b00000, 5'b00000, 0, 64'h8000_0200, 0, 0);

        // Stall counter saturation over 20 fetch-busy cycles
        rst_n = 1'b0;
        step("reset3", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);
        rst_n    = 1'b1;
        ifu_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step("ifu_busy", 5'b11111, 5'b00000, 0, 64'h0, 0, 0);
        end
        clear();
        step("sat_hold", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);

        // Asynchronous reset while a redirect is pending
        ex_br_valid  = 1'b1;
        ex_br_target = 64'h8000_0300;
        id_pc        = 64'h8000_0304;
        step("mispred3", 5'b00000, 5'b00110, 0, 64'h0, 0, 1);
        clear();
        step("pend3", 5'b00001, 5'b00010, 1, 64'h8000_0300, 0, 0);
        rst_n    = 1'b0;
        ifu_busy = 1'b1;
        step("async_reset", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);
        rst_n = 1'b1;
        clear();
        step("post_reset", 5'b00000, 5'b00000, 0, 64'h0, 0, 0);

        checks++;
        if ((exp_q.size() != 0) || (rd_q.size() != 0)) begin
            errors++;
            $display("FAIL drain: got %0d/%0d queued entries, expected 0/0",
                     exp_q.size(), rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
